// File: rtl/decoder38_scan_ctrl.sv
// Select/polarity sequencer feeding a 3-to-8 decoder.
// Prescaled steps in up/down/ping-pong/hold order, continuous or one-shot.
module decoder38_scan_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic             i_load,
    input  logic [2:0]       i_load_val,
    input  logic             i_pol,
    input  logic [CNT_W-1:0] i_div,
    output logic [2:0]       o_sel,
    output logic             o_opt,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_UP   = 2'd0;
    localparam logic [1:0] M_DN   = 2'd1;
    localparam logic [1:0] M_PP   = 2'd2;
    localparam logic [1:0] M_HOLD = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sweep_q, sweep_d;
    logic [2:0]       sel_q, sel_d;
    logic             opt_q, opt_d;
    logic             step_q, step_d;

    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] div_m1;
    logic             tick;
    logic             pp_up;
    logic [4:0]       sweep_nx;
    logic [4:0]       sweep_lim;
    logic             done_hit;

    assign div_eff = (i_div == '0) ? CNT_W'(1) : i_div;
    assign div_m1  = div_eff - CNT_W'(1);
    assign tick    = (state_q == S_RUN) && i_en && (cnt_q == div_m1);

    // Endpoints force the turn so 0 and 7 are never repeated.
    assign pp_up = (sel_q == 3'd0) ? 1'b1 :
                   (sel_q == 3'd7) ? 1'b0 : dir_q;

    assign sweep_nx  = {1'b0, sweep_q} + 5'd1;
    assign sweep_lim = (i_mode == M_PP) ? 5'd14 : 5'd8;
    assign done_hit  = i_oneshot && (sweep_nx >= sweep_lim);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        sweep_d = sweep_q;
        sel_d   = sel_q;
        opt_d   = opt_q;
        step_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_en && (!i_oneshot || i_start)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    sweep_d = '0;
                end
            end
            S_RUN: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (cnt_q >= div_m1) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tick && !i_load) begin
            step_d  = 1'b1;
            opt_d   = i_pol;
            sweep_d = sweep_nx[3:0];
            unique case (i_mode)
                M_UP:   sel_d = sel_q + 3'd1;
                M_DN:   sel_d = sel_q - 3'd1;
                M_PP: begin
                    dir_d = pp_up;
                    sel_d = pp_up ? sel_q + 3'd1 : sel_q - 3'd1;
                end
                M_HOLD: sel_d = sel_q;
            endcase
            if (done_hit) begin
                state_d = S_DONE;
            end
        end

        // A load wins over a coincident tick; that tick is dropped.
        if (i_load) begin
            sel_d = i_load_val;
            opt_d = i_pol;
            dir_d = 1'b1;
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
            sweep_q <= '0;
            sel_q   <= '0;
            opt_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            sel_q   <= sel_d;
            opt_q   <= opt_d;
            step_q  <= step_d;
        end
    end

    assign o_sel  = sel_q;
    assign o_opt  = opt_q;
    assign o_step = step_q;
    assign o_busy = (state_q == S_RUN);
    assign o_done = (state_q == S_DONE);

endmodule
